cpu_program_loader: RTL and testbench
=====================================

# cpu_program_loader

Byte-stream program loader that sits directly upstream of the `cpu` top. It receives a framed byte stream over a valid/ready interface and assembles 32-bit instruction words and 64-bit data words. It writes those words into instruction memory and data memory through the CPU's external memory ports, then drives the CPU `enable` to start and stop execution.

## Interface
Parameters:
- `IMEM_WORDS`, 512: instruction-memory depth in 32-bit words (9-bit index).
- `DMEM_WORDS`, 1024: data-memory depth in 64-bit words (10-bit index).

Ports:
- `clk`  in  1  the single clock.
- `rst`  in  1  synchronous, active-high reset, sampled on the rising edge of `clk`.
- `in_valid`  in  1  stream byte valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader can accept a byte.
- `addr_ext`  out  64  imem byte address (word index × 4).
- `wen_ext`  out  1  imem write strobe, one cycle per word.
- `ren_ext`  out  1  tied 0.
- `wdata_ext`  out  32  imem write word.
- `addr_ext_2`  out  64  dmem byte address (word index × 8).
- `wen_ext_2`  out  1  dmem write strobe.
- `ren_ext_2`  out  1  tied 0.
- `wdata_ext_2`  out  64  dmem write word.
- `cpu_enable`  out  1  drives `cpu.enable`.
- `busy`  out  1  a frame is in progress (state ≠ IDLE/RUN).
- `error`  out  1  sticky error flag.

## Operation
- Frame layout: CMD byte, then for load commands IDX_LO, IDX_HI (start word index), CNT_LO, CNT_HI (word count), then CNT words. Payload words are little-endian: 4 bytes for imem, 8 bytes for dmem.
- Commands:
  - 0x01: load imem.
  - 0x02: load dmem.
  - 0x03: start, sets `cpu_enable`=1.
  - 0x04: stop, clears `cpu_enable`.
  - 0x00: clear `error`.
  - Any other value sets `error` and the loader returns to IDLE.
- States:
  - IDLE: waits for CMD.
  - HDR: 4 header bytes, counted by a 2-bit counter.
  - PAYLOAD: byte counter 0..3 or 0..7; bytes shift into the word register at position [8k+7:8k].
  - WRITE: one cycle.
  - RUN: entered when `cpu_enable`=1.
- PAYLOAD→WRITE on the last byte of a word. WRITE→PAYLOAD if words remain, otherwise →IDLE.
- CNT=0: after the header, return directly to IDLE with no writes.
- Word index wrap/range: the index is 16 bits and increments after every WRITE. A word whose index is ≥ IMEM_WORDS (or ≥ DMEM_WORDS for dmem) is consumed but not written (strobe suppressed), and `error` is set. The index wraps at 0xFFFF→0.
- In RUN, only 0x04 and 0x00 are legal. A load or start command sets `error`, and the loader drains that command's full frame (header plus payload) without writing, so stream alignment is kept.
- Address outputs hold their last value between strobes. Data outputs hold the last written word.

## Timing
- Reset values:
  - Outputs: `in_ready`=0 during the reset cycle and 1 from the first cycle after it. `wen_ext`=`wen_ext_2`=0, all addr/wdata=0, `cpu_enable`=0, `busy`=0, `error`=0.
  - State: IDLE.
- A byte transfers on a rising edge with `in_valid`&&`in_ready`. `in_ready`=1 in all states except WRITE.
- Write latency: final byte of a word accepted at edge N → `wen*`=1 with valid addr/data during cycle N..N+1 (the WRITE cycle). `in_ready` returns high one cycle later. Sustained throughput is 1 word per 5 cycles (imem) or 9 cycles (dmem).
- Start: `cpu_enable` rises in the cycle after the 0x03 byte is accepted. Stop has the same one-cycle latency.
- `rst` asserted mid-frame: next state is IDLE, the partial word is discarded, and no strobe is issued in the reset cycle. `cpu_enable` clears.
- `in_valid` may drop at any byte boundary. The FSM simply waits, with no timeout.

## Structure
- Shared package `loader_pkg` holds:
  - Command codes CMD_LOAD_IMEM/DMEM/START/STOP/CLR.
  - The state enum IDLE/HDR/PAYLOAD/WRITE/RUN.
  - The byte widths 4/8.
- Sub-module `byte_word_assembler` (8-bit in, 64-bit out, byte counter, configurable bytes-per-word 4/8, `word_done` pulse). The FSM, header registers, range check and strobes stay in the top.

## Test plan
- Reset then stream 01 00 00 02 00 | 13 00 00 00 | 93 00 10 00 → `wen_ext` pulses twice: addr 0x0 data 0x00000013, then addr 0x4 data 0x00100093. FSM back to IDLE, `error`=0.
- Stream 02 05 00 01 00 + 8 bytes 01..08 → single `wen_ext_2` pulse, addr 0x28, data 0x0807060504030201.
- Stream 01 FF 01 02 00 + 8 bytes → one write at addr 0x7FC, second word (index 512) suppressed, `error`=1. Then 00 → `error`=0.
- Stream 03 → `cpu_enable`=1 next cycle. Then 01 00 00 01 00 + 4 bytes → no `wen_ext`, `error`=1, stream stays aligned. Then 04 → `cpu_enable`=0.
- Hold `in_valid`=0 for 10 cycles mid-word, then resume → same written data as the unstalled case. Assert `rst` after 2 payload bytes → no strobe, then a fresh frame loads correctly.
- Stream 01 00 00 00 00 → no writes, state IDLE. Stream 07 → `error`=1.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the program loader: command codes, FSM states, word widths.
package loader_pkg;

    localparam logic [7:0] CMD_CLR       = 8'h00;
    localparam logic [7:0] CMD_LOAD_IMEM = 8'h01;
    localparam logic [7:0] CMD_LOAD_DMEM = 8'h02;
    localparam logic [7:0] CMD_START     = 8'h03;
    localparam logic [7:0] CMD_STOP      = 8'h04;

    localparam int unsigned IMEM_BYTES = 4;
    localparam int unsigned DMEM_BYTES = 8;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        PAYLOAD,
        WRITE,
        RUN
    } state_t;

endpackage

// File: rtl/cpu_program_loader_assembler.sv
// Little-endian byte-to-word assembler: 4 or 8 bytes per word, byte k lands at [8k+7:8k].
module byte_word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wide,
    input  logic        i_valid,
    input  logic [7:0]  i_byte,
    output logic [63:0] o_word_next,
    output logic        o_word_done
);

    logic [2:0]  r_cnt;
    logic [63:0] r_word;
    logic [2:0]  w_last_idx;
    logic        w_last;

    assign w_last_idx  = i_wide ? 3'(DMEM_BYTES - 1) : 3'(IMEM_BYTES - 1);
    assign w_last      = (r_cnt == w_last_idx);
    assign o_word_done = i_valid && w_last;

    // Word as it will look with the current byte merged into its lane.
    always_comb begin
        o_word_next = r_word;
        for (int unsigned k = 0; k < 8; k++) begin
            if (k[2:0] == r_cnt) begin
                o_word_next[8*k +: 8] = i_byte;
            end
        end
    end

    // Byte lane counter and word register; counter rewinds after the last byte.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            r_word <= o_word_next;
            r_cnt  <= w_last ? 3'd0 : r_cnt + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Framed byte-stream loader: fills imem/dmem through the CPU external ports and gates cpu_enable.
module cpu_program_loader
    import loader_pkg::*;
#(
    parameter int unsigned IMEM_WORDS = 512,
    parameter int unsigned DMEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    state_t      r_state;
    state_t      w_next;
    state_t      w_home;
    logic [1:0]  r_hdr_cnt;
    logic [15:0] r_idx;
    logic [15:0] r_cnt;
    logic        r_is_dmem;
    logic        r_drain;
    logic        r_cpu_en;
    logic        r_error;
    logic        r_wen;
    logic        r_wen2;
    logic [63:0] r_addr;
    logic [63:0] r_addr2;
    logic [31:0] r_wdata;
    logic [63:0] r_wdata2;

    logic        w_accept;
    logic        w_in_range;
    logic        w_word_done;
    logic [63:0] w_word_next;

    assign in_ready   = !rst && (r_state != WRITE);
    assign w_accept   = in_valid && in_ready;
    // A finished frame returns to RUN if the CPU was left running, so drained frames keep it there.
    assign w_home     = r_cpu_en ? RUN : IDLE;
    assign w_in_range = r_is_dmem ? (32'(r_idx) < DMEM_WORDS) : (32'(r_idx) < IMEM_WORDS);

    assign addr_ext    = r_addr;
    assign wen_ext     = r_wen;
    assign ren_ext     = 1'b0;
    assign wdata_ext   = r_wdata;
    assign addr_ext_2  = r_addr2;
    assign wen_ext_2   = r_wen2;
    assign ren_ext_2   = 1'b0;
    assign wdata_ext_2 = r_wdata2;
    assign cpu_enable  = r_cpu_en;
    assign error       = r_error;
    assign busy        = (r_state == HDR) || (r_state == PAYLOAD) || (r_state == WRITE);

    byte_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .i_wide      (r_is_dmem),
        .i_valid     (w_accept && (r_state == PAYLOAD)),
        .i_byte      (in_data),
        .o_word_next (w_word_next),
        .o_word_done (w_word_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE, RUN: begin
                if (w_accept) begin
                    case (in_data)
                        CMD_LOAD_IMEM, CMD_LOAD_DMEM: w_next = HDR;
                        CMD_START: w_next = RUN;
                        CMD_STOP:  w_next = IDLE;
                        default:   w_next = r_state;
                    endcase
                end
            end
            HDR: begin
                if (w_accept && (r_hdr_cnt == 2'd3)) begin
                    w_next = ({in_data, r_cnt[7:0]} == 16'h0000) ? w_home : PAYLOAD;
                end
            end
            PAYLOAD: begin
                if (w_word_done) begin
                    w_next = WRITE;
                end
            end
            WRITE: begin
                w_next = (r_cnt == 16'd1) ? w_home : PAYLOAD;
            end
            default: w_next = IDLE;
        endcase
    end

    // Command side effects, header capture, range check and write strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hdr_cnt <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_is_dmem <= 1'b0;
            r_drain   <= 1'b0;
            r_cpu_en  <= 1'b0;
            r_error   <= 1'b0;
            r_wen     <= 1'b0;
            r_wen2    <= 1'b0;
            r_addr    <= '0;
            r_addr2   <= '0;
            r_wdata   <= '0;
            r_wdata2  <= '0;
        end else begin
            r_wen  <= 1'b0;
            r_wen2 <= 1'b0;
            unique case (r_state)
                IDLE, RUN: begin
                    if (w_accept) begin
                        case (in_data)
                            CMD_LOAD_IMEM, CMD_LOAD_DMEM: begin
                                r_is_dmem <= (in_data == CMD_LOAD_DMEM);
                                r_drain   <= (r_state == RUN);
                                r_hdr_cnt <= '0;
                                if (r_state == RUN) begin
                                    r_error <= 1'b1;
                                end
                            end
                            CMD_START: begin
                                if (r_state == RUN) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_cpu_en <= 1'b1;
                                end
                            end
                            CMD_STOP: r_cpu_en <= 1'b0;
                            CMD_CLR:  r_error  <= 1'b0;
                            default:  r_error  <= 1'b1;
                        endcase
                    end
                end
                HDR: begin
                    if (w_accept) begin
                        case (r_hdr_cnt)
                            2'd0: r_idx[7:0]  <= in_data;
                            2'd1: r_idx[15:8] <= in_data;
                            2'd2: r_cnt[7:0]  <= in_data;
                            default: r_cnt[15:8] <= in_data;
                        endcase
                        r_hdr_cnt <= r_hdr_cnt + 2'd1;
                    end
                end
                PAYLOAD: begin
                    if (w_word_done && !r_drain) begin
                        if (!w_in_range) begin
                            r_error <= 1'b1;
                        end else if (r_is_dmem) begin
                            r_wen2   <= 1'b1;
                            r_addr2  <= {45'd0, r_idx, 3'b000};
                            r_wdata2 <= w_word_next;
                        end else begin
                            r_wen    <= 1'b1;
                            r_addr   <= {46'd0, r_idx, 2'b00};
                            r_wdata  <= w_word_next[31:0];
                        end
                    end
                end
                WRITE: begin
                    r_idx <= r_idx + 16'd1;
                    r_cnt <= r_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_program_loader.sv
// Directed self-checking bench for cpu_program_loader.
module tb_cpu_program_loader;

    typedef logic [7:0] bytes_t[$];

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    int unsigned compared = 0;
    int unsigned failed   = 0;

    logic [63:0] qa1[$];
    logic [31:0] qd1[$];
    logic [63:0] qa2[$];
    logic [63:0] qd2[$];

    cpu_program_loader #(
        .IMEM_WORDS (512),
        .DMEM_WORDS (1024)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .ren_ext     (ren_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .ren_ext_2   (ren_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .cpu_enable  (cpu_enable),
        .busy        (busy),
        .error       (error)
    );

    always #5 clk = ~clk;

    // Record every write strobe seen mid-cycle.
    always @(negedge clk) begin
        if (wen_ext === 1'b1) begin
            qa1.push_back(addr_ext);
            qd1.push_back(wdata_ext);
        end
        if (wen_ext_2 === 1'b1) begin
            qa2.push_back(addr_ext_2);
            qd2.push_back(wdata_ext_2);
        end
    end

    task automatic flush();
        qa1.delete(); qd1.delete(); qa2.delete(); qd2.delete();
    endtask

    task automatic idle(input int unsigned n);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned waited = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            compared++;
            failed++;
            $display("FAIL send_byte_timeout: in_ready=%b required 1 for byte %h", in_ready, b);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
        end
    endtask

    task automatic send_seq(input bytes_t s);
        foreach (s[i]) send_byte(s[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        compared++;
        if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready_low: got %b required 0", in_ready); end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (in_ready !== 1'b1) begin failed++; $display("FAIL reset_in_ready_high: got %b required 1", in_ready); end
        compared++;
        if ({wen_ext, wen_ext_2, cpu_enable, busy, error} !== 5'b0) begin
            failed++; $display("FAIL reset_flags: got %b required 00000", {wen_ext, wen_ext_2, cpu_enable, busy, error});
        end
        compared++;
        if ({addr_ext, addr_ext_2, wdata_ext, wdata_ext_2} !== '0) begin
            failed++; $display("FAIL reset_buses: got %h %h %h %h required 0", addr_ext, addr_ext_2, wdata_ext, wdata_ext_2);
        end
    endtask

    task automatic test_imem_load();
        flush();
        send_seq('{8'h01, 8'h00, 8'h00, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00});
        compared++;
        if (busy !== 1'b1) begin failed++; $display("FAIL imem_busy: got %b required 1", busy); end
        send_seq('{8'h93, 8'h00, 8'h10, 8'h00});
        @(negedge clk);
        compared++;
        if ({wen_ext, in_ready} !== 2'b10) begin
            failed++; $display("FAIL imem_write_cycle: wen/in_ready got %b required 10", {wen_ext, in_ready});
        end
        idle(3);
        compared++;
        if (qa1.size() !== 2) begin failed++; $display("FAIL imem_count: got %0d required 2", qa1.size()); end
        compared++;
        if (qa1.size() >= 2 && (qa1[0] !== 64'h0 || qd1[0] !== 32'h00000013)) begin
            failed++; $display("FAIL imem_word0: got %h/%h required 0/00000013", qa1[0], qd1[0]);
        end
        compared++;
        if (qa1.size() >= 2 && (qa1[1] !== 64'h4 || qd1[1] !== 32'h00100093)) begin
            failed++; $display("FAIL imem_word1: got %h/%h required 4/00100093", qa1[1], qd1[1]);
        end
        compared++;
        if ({busy, error, wdata_ext} !== {2'b00, 32'h00100093}) begin
            failed++; $display("FAIL imem_after: busy/error/wdata got %b%b %h required 00 00100093", busy, error, wdata_ext);
        end
    endtask

    task automatic test_dmem_load();
        flush();
        send_seq('{8'h02, 8'h05, 8'h00, 8'h01, 8'h00,
                   8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08});
        idle(3);
        compared++;
        if (qa2.size() !== 1 || qa1.size() !== 0) begin
            failed++; $display("FAIL dmem_count: got %0d/%0d required 1/0", qa2.size(), qa1.size());
        end
        compared++;
        if (qa2.size() >= 1 && (qa2[0] !== 64'h28 || qd2[0] !== 64'h0807060504030201)) begin
            failed++; $display("FAIL dmem_word: got %h/%h required 28/0807060504030201", qa2[0], qd2[0]);
        end
    endtask

    task automatic test_range();
        flush();
        send_seq('{8'h01, 8'hFF, 8'h01, 8'h02, 8'h00,
                   8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
        idle(3);
        compared++;
        if (qa1.size() !== 1) begin failed++; $display("FAIL range_count: got %0d required 1", qa1.size()); end
        compared++;
        if (qa1.size() >= 1 && (qa1[0] !== 64'h7FC || qd1[0] !== 32'h44332211)) begin
            failed++; $display("FAIL range_word: got %h/%h required 7FC/44332211", qa1[0], qd1[0]);
        end
        compared++;
        if (error !== 1'b1) begin failed++; $display("FAIL range_error: got %b required 1", error); end
        send_byte(8'h00);
        idle(1);
        compared++;
        if (error !== 1'b0) begin failed++; $display("FAIL range_clear: got %b required 0", error); end
        // index 0xFFFF is out of range, the next wraps to 0 and is written
        flush();
        send_seq('{8'h01, 8'hFF, 8'hFF, 8'h02, 8'h00,
                   8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4});
        idle(3);
        compared++;
        if (qa1.size() !== 1 || error !== 1'b1) begin
            failed++; $display("FAIL wrap_count: got %0d err %b required 1 err 1", qa1.size(), error);
        end
        compared++;
        if (qa1.size() >= 1 && (qa1[0] !== 64'h0 || qd1[0] !== 32'hB4B3B2B1)) begin
            failed++; $display("FAIL wrap_word: got %h/%h required 0/B4B3B2B1", qa1[0], qd1[0]);
        end
        send_byte(8'h00);
        idle(1);
    endtask

    task automatic test_back_to_back();
        flush();
        // dmem index 1023 is the last valid word; 1024 is consumed but suppressed
        send_seq('{8'h02, 8'hFF, 8'h03, 8'h02, 8'h00,
                   8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17,
                   8'h20, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h27});
        idle(3);
        compared++;
        if (qa2.size() !== 1) begin failed++; $display("FAIL b2b_count: got %0d required 1", qa2.size()); end
        compared++;
        if (qa2.size() >= 1 && (qa2[0] !== 64'h1FF8 || qd2[0] !== 64'h1716151413121110)) begin
            failed++; $display("FAIL b2b_word: got %h/%h required 1FF8/1716151413121110", qa2[0], qd2[0]);
        end
        compared++;
        if ({error, wdata_ext_2} !== {1'b1, 64'h1716151413121110}) begin
            failed++; $display("FAIL b2b_hold: err/data got %b %h required 1 1716151413121110", error, wdata_ext_2);
        end
        send_byte(8'h00);
        idle(1);
    endtask

    task automatic test_run();
        flush();
        send_byte(8'h03);
        @(negedge clk);
        compared++;
        if (cpu_enable !== 1'b1) begin failed++; $display("FAIL start_enable: got %b required 1", cpu_enable); end
        send_seq('{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD});
        idle(3);
        compared++;
        if (qa1.size() !== 0 || error !== 1'b1 || busy !== 1'b0) begin
            failed++; $display("FAIL run_drain: writes %0d err %b busy %b required 0 1 0", qa1.size(), error, busy);
        end
        send_byte(8'h00);
        idle(1);
        compared++;
        if ({error, cpu_enable} !== 2'b01) begin
            failed++; $display("FAIL run_clear: err/en got %b required 01", {error, cpu_enable});
        end
        send_byte(8'h04);
        @(negedge clk);
        compared++;
        if (cpu_enable !== 1'b0) begin failed++; $display("FAIL stop_enable: got %b required 0", cpu_enable); end
        send_seq('{8'h01, 8'h03, 8'h00, 8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE});
        idle(3);
        compared++;
        if (qa1.size() !== 1 || qa1[0] !== 64'hC || qd1[0] !== 32'hDEADBEEF) begin
            failed++; $display("FAIL run_aligned: count %0d got %h/%h required 1 C/DEADBEEF",
                               qa1.size(), qa1.size() > 0 ? qa1[0] : '0, qd1.size() > 0 ? qd1[0] : '0);
        end
    endtask

    task automatic test_stall_and_reset();
        flush();
        send_seq('{8'h01, 8'h10, 8'h00, 8'h01, 8'h00, 8'h78, 8'h56});
        idle(10);
        send_seq('{8'h34, 8'h12});
        idle(3);
        compared++;
        if (qa1.size() !== 1 || qa1[0] !== 64'h40 || qd1[0] !== 32'h12345678) begin
            failed++; $display("FAIL stall_word: count %0d got %h/%h required 1 40/12345678",
                               qa1.size(), qa1.size() > 0 ? qa1[0] : '0, qd1.size() > 0 ? qd1[0] : '0);
        end
        flush();
        send_seq('{8'h01, 8'h00, 8'h00, 8'h01, 8'h00, 8'hAA, 8'hBB});
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if ({wen_ext, busy, in_ready} !== 3'b000) begin
            failed++; $display("FAIL midreset_state: wen/busy/ready got %b required 000", {wen_ext, busy, in_ready});
        end
        rst = 1'b0;
        send_seq('{8'h01, 8'h01, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44});
        idle(3);
        compared++;
        if (qa1.size() !== 1 || qa1[0] !== 64'h4 || qd1[0] !== 32'h44332211) begin
            failed++; $display("FAIL midreset_reload: count %0d got %h/%h required 1 4/44332211",
                               qa1.size(), qa1.size() > 0 ? qa1[0] : '0, qd1.size() > 0 ? qd1[0] : '0);
        end
    endtask

    task automatic test_cnt_zero_and_bad_cmd();
        flush();
        send_seq('{8'h01, 8'h00, 8'h00, 8'h00, 8'h00});
        idle(3);
        compared++;
        if (qa1.size() !== 0 || busy !== 1'b0 || error !== 1'b0) begin
            failed++; $display("FAIL cnt0: writes %0d busy %b err %b required 0 0 0", qa1.size(), busy, error);
        end
        send_byte(8'h07);
        idle(1);
        compared++;
        if ({error, busy} !== 2'b10) begin failed++; $display("FAIL bad_cmd: err/busy got %b required 10", {error, busy}); end
        send_byte(8'h00);
        idle(1);
        compared++;
        if (error !== 1'b0) begin failed++; $display("FAIL bad_cmd_clear: got %b required 0", error); end
    endtask

    initial begin
        test_reset();
        test_imem_load();
        test_dmem_load();
        test_range();
        test_back_to_back();
        test_run();
        test_stall_and_reset();
        test_cnt_zero_and_bad_cmd();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
        $finish;
    end

endmodule
